// File: rtl/mem_arb_pkg.sv
// Arbiter FSM state and bus-owner encodings shared by mem_req_arbiter and mem_arb_sel.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_IF,
        GRANT_MEM,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Signal bundle between the IF/MEM ports, the arbiter (slave) and its environment (master).
interface mem_req_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
);
    logic                  if_valid_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic [1:0]            if_size_i;
    logic                  if_ready_o;
    logic [DATA_WIDTH-1:0] if_rdata_o;
    logic [1:0]            if_resp_o;

    logic                  mem_valid_i;
    logic                  mem_req_i;
    logic [ADDR_WIDTH-1:0] mem_addr_i;
    logic [1:0]            mem_size_i;
    logic [DATA_WIDTH-1:0] mem_wdata_i;
    logic [7:0]            mem_strb_i;
    logic                  mem_ready_o;
    logic [DATA_WIDTH-1:0] mem_rdata_o;
    logic [1:0]            mem_resp_o;

    logic                  rw_valid_o;
    logic                  rw_ready_i;
    logic                  rw_req_o;
    logic [ADDR_WIDTH-1:0] rw_addr_o;
    logic [1:0]            rw_size_o;
    logic [DATA_WIDTH-1:0] data_write_o;
    logic [7:0]            strb_mask_o;
    logic                  axi_sig_mem_o;
    logic [DATA_WIDTH-1:0] data_read_i;
    logic [1:0]            rw_resp_i;

    modport slave (
        input  if_valid_i, if_addr_i, if_size_i,
        output if_ready_o, if_rdata_o, if_resp_o,
        input  mem_valid_i, mem_req_i, mem_addr_i, mem_size_i, mem_wdata_i, mem_strb_i,
        output mem_ready_o, mem_rdata_o, mem_resp_o,
        output rw_valid_o, rw_req_o, rw_addr_o, rw_size_o, data_write_o, strb_mask_o,
        output axi_sig_mem_o,
        input  rw_ready_i, data_read_i, rw_resp_i
    );

    modport master (
        output if_valid_i, if_addr_i, if_size_i,
        input  if_ready_o, if_rdata_o, if_resp_o,
        output mem_valid_i, mem_req_i, mem_addr_i, mem_size_i, mem_wdata_i, mem_strb_i,
        input  mem_ready_o, mem_rdata_o, mem_resp_o,
        input  rw_valid_o, rw_req_o, rw_addr_o, rw_size_o, data_write_o, strb_mask_o,
        input  axi_sig_mem_o,
        output rw_ready_i, data_read_i, rw_resp_i
    );
endinterface

// File: rtl/config.sv
// Shared request-type and access-size encodings for the memory request path.
`ifndef CONFIG_SV
`define CONFIG_SV

`define REQ_READ  1'b0
`define REQ_WRITE 1'b1

`define SIZE_B 2'b00
`define SIZE_H 2'b01
`define SIZE_W 2'b10
`define SIZE_D 2'b11

`endif

// File: rtl/mem_arb_sel.sv
// Grant selection between IF and MEM requests.
// ARB_ROUND_ROBIN_EN: alternate on simultaneous requests; otherwise MEM has fixed priority.
module mem_arb_sel
    import mem_arb_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   if_valid,
    input  logic   mem_valid,
    input  logic   take,
    output logic   grant,
    output owner_t owner
);
    assign grant = if_valid | mem_valid;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_grant;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= OWN_IF;
        end else if (take) begin
            last_grant <= owner;
        end
    end

    // On a tie the port that lost last time wins; a lone request always wins.
    always_comb begin
        owner = OWN_IF;
        if (if_valid && mem_valid) begin
            owner = (last_grant == OWN_IF) ? OWN_MEM : OWN_IF;
        end else if (mem_valid) begin
            owner = OWN_MEM;
        end
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clock, reset, take};

    assign owner = mem_valid ? OWN_MEM : OWN_IF;
`endif

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates the IF and MEM ports onto the single rw_* request interface of the AXI master.
// Build option ARB_ROUND_ROBIN_EN (tested in mem_arb_sel) enables round-robin tie-breaking.
`include "config.sv"

module mem_req_arbiter
    import mem_arb_pkg::*;
(
    input logic              clock,
    input logic              reset,
    mem_req_arbiter_if.slave bus
);
    arb_state_t state;
    logic       valid_q;
    logic       sel_grant;
    logic       sel_take;
    owner_t     sel_owner;

    assign sel_take = (state == IDLE) && sel_grant;

    mem_arb_sel u_sel (
        .clock     (clock),
        .reset     (reset),
        .if_valid  (bus.if_valid_i),
        .mem_valid (bus.mem_valid_i),
        .take      (sel_take),
        .grant     (sel_grant),
        .owner     (sel_owner)
    );

    // Dropped in the done cycle so the master does not see a second request.
    assign bus.rw_valid_o = valid_q & ~bus.rw_ready_i;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            valid_q           <= 1'b0;
            bus.axi_sig_mem_o <= 1'b0;
            bus.rw_req_o      <= 1'b0;
            bus.rw_addr_o     <= '0;
            bus.rw_size_o     <= '0;
            bus.data_write_o  <= '0;
            bus.strb_mask_o   <= '0;
            bus.if_ready_o    <= 1'b0;
            bus.if_rdata_o    <= '0;
            bus.if_resp_o     <= '0;
            bus.mem_ready_o   <= 1'b0;
            bus.mem_rdata_o   <= '0;
            bus.mem_resp_o    <= '0;
        end else begin
            bus.if_ready_o  <= 1'b0;
            bus.mem_ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_grant) begin
                        valid_q           <= 1'b1;
                        bus.axi_sig_mem_o <= (sel_owner == OWN_MEM);
                        if (sel_owner == OWN_MEM) begin
                            bus.rw_req_o     <= bus.mem_req_i;
                            bus.rw_addr_o    <= bus.mem_addr_i;
                            bus.rw_size_o    <= bus.mem_size_i;
                            bus.data_write_o <= bus.mem_wdata_i;
                            bus.strb_mask_o  <= bus.mem_strb_i;
                            state            <= GRANT_MEM;
                        end else begin
                            bus.rw_req_o     <= `REQ_READ;
                            bus.rw_addr_o    <= bus.if_addr_i;
                            bus.rw_size_o    <= bus.if_size_i;
                            bus.data_write_o <= '0;
                            bus.strb_mask_o  <= '0;
                            state            <= GRANT_IF;
                        end
                    end
                end
                GRANT_IF, GRANT_MEM: begin
                    if (bus.rw_ready_i) begin
                        valid_q <= 1'b0;
                        state   <= DONE;
                        if (state == GRANT_MEM) begin
                            bus.mem_rdata_o <= bus.data_read_i;
                            bus.mem_resp_o  <= bus.rw_resp_i;
                            bus.mem_ready_o <= 1'b1;
                        end else begin
                            bus.if_rdata_o <= bus.data_read_i;
                            bus.if_resp_o  <= bus.rw_resp_i;
                            bus.if_ready_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of the arbitration rules.
module tb_mem_req_arbiter;
    localparam int         DW     = 64;
    localparam int         AW     = 64;
    localparam logic       REQ_RD = 1'b0;
    localparam logic       REQ_WR = 1'b1;
    localparam logic [1:0] SZ_W   = 2'b10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_req_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_req_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        req;
        logic [63:0] addr;
        logic [1:0]  size;
        logic [63:0] wdata;
        logic [7:0]  strb;
    } req_t;

    int vectors     = 0;
    int miscompares = 0;

    req_t        if_r, mem_r, cap;
    bit          if_act, mem_act;
    int          own;          // -1 none, 0 IF, 1 MEM
    bit          done_ph;
    int          lat;
    bit          rdy_drv;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_resp;
    bit          rand_en;
    int          fix_lat;
    logic [63:0] dir_data;
    logic [1:0]  dir_resp;
    int          last_win;
    int          grant_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ports();
        bus.if_valid_i  = if_act;
        bus.if_addr_i   = if_r.addr;
        bus.if_size_i   = if_r.size;
        bus.mem_valid_i = mem_act;
        bus.mem_req_i   = mem_r.req;
        bus.mem_addr_i  = mem_r.addr;
        bus.mem_size_i  = mem_r.size;
        bus.mem_wdata_i = mem_r.wdata;
        bus.mem_strb_i  = mem_r.strb;
        bus.rw_ready_i  = rdy_drv;
        bus.data_read_i = rdy_drv ? exp_rdata : {$urandom, $urandom};
        bus.rw_resp_i   = rdy_drv ? exp_resp : 2'($urandom_range(0, 3));
    endtask

    function automatic req_t rand_req(input bit is_mem);
        req_t r;
        r.req   = is_mem ? 1'($urandom_range(0, 1)) : REQ_RD;
        r.addr  = {$urandom, $urandom};
        r.size  = 2'($urandom_range(0, 3));
        r.wdata = {$urandom, $urandom};
        r.strb  = 8'($urandom_range(0, 255));
        return r;
    endfunction

    function automatic int pick();
`ifdef ARB_ROUND_ROBIN_EN
        if (if_act && mem_act) return (last_win == 0) ? 1 : 0;
`endif
        return mem_act ? 1 : 0;
    endfunction

    // End-of-cycle bookkeeping: what the next cycle must look like.
    task automatic advance();
        if (done_ph) begin
            done_ph = 0;
            own     = -1;
        end else if (own >= 0) begin
            if (rdy_drv) done_ph = 1;
        end else if (if_act || mem_act) begin
            own      = pick();
            last_win = own;
            grant_log.push_back(own);
            if (own == 1) begin
                cap = mem_r;
            end else begin
                cap      = '0;
                cap.req  = REQ_RD;
                cap.addr = if_r.addr;
                cap.size = if_r.size;
            end
            lat = rand_en ? $urandom_range(0, 3) : fix_lat;
        end
    endtask

    task automatic check();
        bit gnt;
        gnt = (own >= 0) && !done_ph;
        chk("rw_valid", 64'(bus.rw_valid_o), 64'(gnt && !rdy_drv));
        if (gnt) begin
            chk("axi_sig_mem", 64'(bus.axi_sig_mem_o), 64'(own == 1));
            chk("rw_req",      64'(bus.rw_req_o),      64'(cap.req));
            chk("rw_addr",     bus.rw_addr_o,          cap.addr);
            chk("rw_size",     64'(bus.rw_size_o),     64'(cap.size));
            chk("data_write",  bus.data_write_o,       cap.wdata);
            chk("strb_mask",   64'(bus.strb_mask_o),   64'(cap.strb));
        end
        chk("if_ready",  64'(bus.if_ready_o),  64'(done_ph && own == 0));
        chk("mem_ready", 64'(bus.mem_ready_o), 64'(done_ph && own == 1));
        if (done_ph && own == 1) begin
            chk("mem_rdata", bus.mem_rdata_o,     exp_rdata);
            chk("mem_resp",  64'(bus.mem_resp_o), 64'(exp_resp));
        end else if (done_ph) begin
            chk("if_rdata", bus.if_rdata_o,     exp_rdata);
            chk("if_resp",  64'(bus.if_resp_o), 64'(exp_resp));
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        rdy_drv = 0;
        if (done_ph) begin
            if (own == 1) mem_act = 0;
            else          if_act  = 0;
        end else if (own >= 0) begin
            if (lat == 0) begin
                rdy_drv   = 1;
                exp_rdata = rand_en ? {$urandom, $urandom} : dir_data;
                exp_resp  = rand_en ? 2'($urandom_range(0, 3)) : dir_resp;
            end else begin
                lat--;
            end
        end
        if (rand_en) begin
            if (!if_act && $urandom_range(0, 2) == 0) begin
                if_r   = rand_req(1'b0);
                if_act = 1;
            end
            if (!mem_act && $urandom_range(0, 2) == 0) begin
                mem_r   = rand_req(1'b1);
                mem_act = 1;
            end
        end
        drive_ports();
        #1;
        check();
        advance();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " rw_valid"},    64'(bus.rw_valid_o),    64'd0);
        chk({tag, " if_ready"},    64'(bus.if_ready_o),    64'd0);
        chk({tag, " mem_ready"},   64'(bus.mem_ready_o),   64'd0);
        chk({tag, " axi_sig_mem"}, 64'(bus.axi_sig_mem_o), 64'd0);
        chk({tag, " rw_req"},      64'(bus.rw_req_o),      64'd0);
        chk({tag, " rw_addr"},     bus.rw_addr_o,          64'd0);
        chk({tag, " rw_size"},     64'(bus.rw_size_o),     64'd0);
        chk({tag, " data_write"},  bus.data_write_o,       64'd0);
        chk({tag, " strb_mask"},   64'(bus.strb_mask_o),   64'd0);
        chk({tag, " if_rdata"},    bus.if_rdata_o,         64'd0);
        chk({tag, " mem_rdata"},   bus.mem_rdata_o,        64'd0);
        chk({tag, " if_resp"},     64'(bus.if_resp_o),     64'd0);
        chk({tag, " mem_resp"},    64'(bus.mem_resp_o),    64'd0);
    endtask

    initial begin
        if_r = '0; mem_r = '0; cap = '0;
        if_act = 0; mem_act = 0; own = -1; done_ph = 0; lat = 0; rdy_drv = 0;
        exp_rdata = '0; exp_resp = '0; rand_en = 0; fix_lat = 0;
        dir_data = '0; dir_resp = '0; last_win = 0;
        drive_ports();

        // Reset state
        #12;
        check_all_zero("reset");
        #10 reset = 1'b0;

        // IF only, rw_ready on first grant cycle
        if_r      = '0;
        if_r.addr = 64'h8000_0000;
        if_r.size = SZ_W;
        if_act    = 1;
        fix_lat   = 0;
        dir_data  = 64'h1234;
        dir_resp  = 2'b00;
        repeat (5) cycle();

        // MEM store
        mem_r       = '0;
        mem_r.req   = REQ_WR;
        mem_r.addr  = 64'h8000_0010;
        mem_r.size  = SZ_W;
        mem_r.wdata = 64'hdead_beef;
        mem_r.strb  = 8'h0f;
        mem_act     = 1;
        fix_lat     = 2;
        dir_data    = 64'h5555_aaaa_0000_ffff;
        dir_resp    = 2'b10;
        repeat (7) cycle();

        // Simultaneous IF+MEM, repeated
        grant_log.delete();
        for (int k = 0; k < 4; k++) begin
            if_r      = rand_req(1'b0);
            if_act    = 1;
            mem_r     = rand_req(1'b1);
            mem_act   = 1;
            fix_lat   = 1;
            dir_data  = {$urandom, $urandom};
            dir_resp  = 2'b01;
            repeat (10) cycle();
        end
`ifndef ARB_ROUND_ROBIN_EN
        chk("sim_first_mem", 64'(grant_log.size() > 1 && grant_log[0] == 1 && grant_log[1] == 0), 64'd1);
`endif

        // Reset mid-grant
        if_r      = '0;
        if_r.addr = 64'h8000_0040;
        if_r.size = SZ_W;
        if_act    = 1;
        fix_lat   = 6;
        repeat (3) cycle();
        chk("pre_reset rw_valid", 64'(bus.rw_valid_o), 64'd1);
        #1 reset = 1'b1;
        #1 check_all_zero("midreset");
        #3 reset = 1'b0;
        own = -1; done_ph = 0; rdy_drv = 0; last_win = 0;
        fix_lat  = 1;
        dir_data = 64'hcafe_f00d;
        dir_resp = 2'b00;
        drive_ports();
        advance();
        repeat (6) cycle();

        // Randomized traffic
        rand_en = 1;
        repeat (600) cycle();
        rand_en = 0;
        fix_lat = 0;
        repeat (30) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
